// File: rtl/display_scheduler_16b.sv
// rtl/display_scheduler_16b.sv - four-source capture buffer with round-robin timed display selection
module display_scheduler_16b #(
    parameter int HOLD_CYCLES = 50000000,
    parameter int CNT_W       = 26
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [3:0]  REQ,
    input  logic [15:0] DATA_0,
    input  logic [15:0] DATA_1,
    input  logic [15:0] DATA_2,
    input  logic [15:0] DATA_3,
    input  logic        CLR,
    input  logic        FREEZE,
    output logic [3:0]  ACK,
    output logic [15:0] DISP_DATA,
    output logic [1:0]  DISP_SRC,
    output logic        DISP_VALID
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHOW,
        ST_ADVANCE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

    state_t           state_q, state_d;
    logic [15:0]      buf_q [4];
    logic [15:0]      buf_d [4];
    logic [15:0]      data_in [4];
    logic [3:0]       vld_q, vld_d;
    logic [3:0]       ack_q, ack_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       ptr_q, ptr_d;

    assign data_in[0] = DATA_0;
    assign data_in[1] = DATA_1;
    assign data_in[2] = DATA_2;
    assign data_in[3] = DATA_3;

    // First valid index after 'from', wrapping; 'from' itself is the last candidate.
    function automatic logic [1:0] next_valid(input logic [1:0] from, input logic [3:0] vld);
        logic [1:0] idx;
        next_valid = from;
        for (int k = 4; k >= 1; k--) begin
            idx = from + 2'(k);
            if (vld[idx]) next_valid = idx;
        end
    endfunction

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        vld_d   = vld_q;
        ack_d   = REQ & {4{~CLR}};
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        if (CLR) begin
            for (int i = 0; i < 4; i++) buf_d[i] = '0;
            vld_d   = '0;
            cnt_d   = '0;
            state_d = ST_IDLE;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (REQ[i]) begin
                    buf_d[i] = data_in[i];
                    vld_d[i] = 1'b1;
                end
            end
            case (state_q)
                ST_IDLE: begin
                    if (vld_q != 4'b0000) begin
                        sel_d   = next_valid(ptr_q, vld_q);
                        ptr_d   = sel_d;
                        cnt_d   = '0;
                        state_d = ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    if (!FREEZE) begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_d   = '0;
                            state_d = ST_ADVANCE;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                ST_ADVANCE: begin
                    sel_d   = next_valid(sel_q, vld_q);
                    ptr_d   = sel_d;
                    state_d = ST_SHOW;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            for (int i = 0; i < 4; i++) buf_q[i] <= '0;
            vld_q   <= '0;
            ack_q   <= '0;
            cnt_q   <= '0;
            sel_q   <= 2'd0;
            ptr_q   <= 2'd3;
        end else begin
            state_q <= state_d;
            for (int i = 0; i < 4; i++) buf_q[i] <= buf_d[i];
            vld_q   <= vld_d;
            ack_q   <= ack_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

    // ADVANCE keeps the outgoing source on display, so only IDLE blanks the output.
    assign ACK        = ack_q;
    assign DISP_VALID = (state_q != ST_IDLE);
    assign DISP_DATA  = DISP_VALID ? buf_q[sel_q] : 16'h0000;
    assign DISP_SRC   = sel_q;

endmodule

// File: tb/tb_display_scheduler_16b.sv
// tb/tb_display_scheduler_16b.sv - directed self-checking bench for display_scheduler_16b
module tb_display_scheduler_16b;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [3:0]  REQ = 4'b0000;
    logic [15:0] DATA_0 = 16'h0000;
    logic [15:0] DATA_1 = 16'h0000;
    logic [15:0] DATA_2 = 16'h0000;
    logic [15:0] DATA_3 = 16'h0000;
    logic        CLR = 1'b0;
    logic        FREEZE = 1'b0;
    logic [3:0]  ACK;
    logic [15:0] DISP_DATA;
    logic [1:0]  DISP_SRC;
    logic        DISP_VALID;

    int checks = 0;
    int errors = 0;

    logic [1:0]  seq [3];
    logic [15:0] exp_buf [4];
    logic [1:0]  exp_src;

    display_scheduler_16b #(.HOLD_CYCLES(4), .CNT_W(3)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ),
        .DATA_0(DATA_0), .DATA_1(DATA_1), .DATA_2(DATA_2), .DATA_3(DATA_3),
        .CLR(CLR), .FREEZE(FREEZE), .ACK(ACK),
        .DISP_DATA(DISP_DATA), .DISP_SRC(DISP_SRC), .DISP_VALID(DISP_VALID)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_disp(input string tag, input logic v, input logic [1:0] s, input logic [15:0] d);
        chk({tag, "_valid"}, 16'(DISP_VALID), 16'(v));
        chk({tag, "_src"},   16'(DISP_SRC),   16'(s));
        chk({tag, "_data"},  DISP_DATA,       d);
    endtask

    initial begin
        // reset state
        #1;
        chk_disp("rst", 1'b0, 2'd0, 16'h0000);
        chk("rst_ack", 16'(ACK), 16'h0);
        step();
        RST = 1'b0;
        step();

        // single source 2 stays on display through repeated periods
        REQ = 4'b0100; DATA_2 = 16'hBEEF;
        step();
        REQ = 4'b0000;
        chk("k_ack", 16'(ACK), 16'h4);
        chk("k_valid", 16'(DISP_VALID), 16'h0);
        step();
        chk("k1_ack", 16'(ACK), 16'h0);
        chk_disp("k1", 1'b1, 2'd2, 16'hBEEF);
        for (int i = 0; i < 12; i++) begin
            step();
            chk_disp("solo", 1'b1, 2'd2, 16'hBEEF);
        end

        // async reset mid-SHOW, then restart on source 3
        #3 RST = 1'b1;
        #1;
        chk_disp("arst", 1'b0, 2'd0, 16'h0000);
        chk("arst_ack", 16'(ACK), 16'h0);
        step();
        RST = 1'b0;
        REQ = 4'b1000; DATA_3 = 16'h3C3C;
        step();
        REQ = 4'b0000;
        step();
        chk_disp("post_rst", 1'b1, 2'd3, 16'h3C3C);

        // clean start for rotation
        RST = 1'b1;
        #1 RST = 1'b0;
        step();

        // sources 0,1,3 rotate with 5-cycle periods; capture into 1 while shown
        seq[0] = 2'd0; seq[1] = 2'd1; seq[2] = 2'd3;
        exp_buf[0] = 16'h1111; exp_buf[1] = 16'h2222; exp_buf[2] = 16'h0000; exp_buf[3] = 16'h3333;
        REQ = 4'b1011; DATA_0 = 16'h1111; DATA_1 = 16'h2222; DATA_3 = 16'h3333;
        step();
        for (int j = 0; j < 20; j++) begin
            if (j == 8) begin
                REQ = 4'b0010; DATA_1 = 16'hA5A5;
            end else begin
                REQ = 4'b0000;
            end
            step();
            if (j == 8) begin
                exp_buf[1] = 16'hA5A5;
                chk("inj_ack", 16'(ACK), 16'h2);
            end
            exp_src = seq[(j / 5) % 3];
            chk_disp("rot", 1'b1, exp_src, exp_buf[exp_src]);
        end

        // freeze on source 1 for 10 cycles starting from counter value 1
        for (int j = 20; j < 40; j++) begin
            FREEZE = (j >= 22 && j <= 31);
            step();
            exp_src = (j <= 34) ? 2'd1 : 2'd3;
            chk_disp("frz", 1'b1, exp_src, exp_buf[exp_src]);
        end
        FREEZE = 1'b0;

        // clear wins over simultaneous requests
        CLR = 1'b1; REQ = 4'b1111;
        step();
        CLR = 1'b0; REQ = 4'b0000;
        chk("clr_ack", 16'(ACK), 16'h0);
        chk("clr_valid", 16'(DISP_VALID), 16'h0);
        chk("clr_data", DISP_DATA, 16'h0000);
        step();
        chk("clr_novld", 16'(DISP_VALID), 16'h0);
        step();
        chk("clr_idle", 16'(DISP_VALID), 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/display_scheduler_16b.md
DISPLAY_SCHEDULER_16B -- requirements
Module: display_scheduler_16b

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 50000000, giving the number of SHOW cycles each source is displayed (must be at least 2).
REQ-002 The block SHALL have parameter CNT_W, default 26, giving the hold counter width; the counter must be able to hold HOLD_CYCLES-1.
REQ-003 The block SHALL have port CLK, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port RST, input, 1 bit, reset, asynchronous and active-high.
REQ-005 The block SHALL have port REQ, input, 4 bits; REQ[i] high means source i posts DATA_i this cycle.
REQ-006 The block SHALL have ports DATA_0, DATA_1, DATA_2 and DATA_3, input, 16 bits each, the source values.
REQ-007 The block SHALL have port CLR, input, 1 bit, synchronous clear of all stored values.
REQ-008 The block SHALL have port FREEZE, input, 1 bit; while high, the current source stays on display.
REQ-009 The block SHALL have port ACK, output, 4 bits; ACK[i] is a one-cycle capture acknowledge.
REQ-010 The block SHALL have port DISP_DATA, output, 16 bits, the value to drive the 4-digit hex segment decoder.
REQ-011 The block SHALL have port DISP_SRC, output, 2 bits, the index of the displayed source.
REQ-012 The block SHALL have port DISP_VALID, output, 1 bit, high when a stored source is being displayed.

Function
REQ-013 Capture: on each rising edge with REQ[i]=1 and CLR=0, the block SHALL store DATA_i into BUF[i] and set VLD[i]=1; all four sources capture independently in the same cycle, with no contention.
REQ-014 Acknowledge: ACK[i] SHALL be a register equal to (REQ[i] and not CLR) from the previous edge; a held REQ therefore produces a capture and an ACK every cycle.
REQ-015 Clear: CLR=1 at an edge SHALL zero BUF, VLD, ACK and the counter and force IDLE; CLR overrides REQ and FREEZE in the same cycle.
REQ-016 The state machine SHALL have three states: IDLE, SHOW and ADVANCE.
REQ-017 IDLE SHALL drive DISP_VALID=0 and DISP_DATA=0, and hold DISP_SRC at its last value.
REQ-018 IDLE to SHOW SHALL occur at the first edge where VLD is non-zero; SEL becomes the first index with VLD=1 searching PTR+1, PTR+2, ... modulo 4, and the counter is set to 0.
REQ-019 SHOW SHALL drive DISP_VALID=1 and DISP_DATA=BUF[SEL] combinationally, so a capture into the displayed source appears right after the capturing edge; DISP_SRC SHALL equal SEL.
REQ-020 In SHOW the counter SHALL increment each cycle while FREEZE=0 and hold while FREEZE=1.
REQ-021 At counter=HOLD_CYCLES-1 with FREEZE=0, the machine SHALL go to ADVANCE and reset the counter to 0.
REQ-022 ADVANCE SHALL last exactly one cycle with outputs unchanged; SEL then becomes the next VLD index after SEL, wrapping 3 to 0, and becomes SEL itself if it is the only valid source; the machine then returns to SHOW.
REQ-023 Each source SHALL therefore be displayed for HOLD_CYCLES+1 cycles when FREEZE is low.
REQ-024 PTR SHALL record SEL on every SHOW entry.
REQ-025 FREEZE arriving in the ADVANCE cycle SHALL not block that advance; it takes effect in the following SHOW.

Reset
REQ-026 RST=1 SHALL immediately and asynchronously clear BUF to 0, VLD to 0, ACK to 0, the counter to 0, SEL to 0, PTR to 3, state to IDLE, DISP_DATA to 0, DISP_SRC to 0 and DISP_VALID to 0.
REQ-027 RST asserted mid-SHOW SHALL abandon the display with no extra cycles; after release, the first REQ restarts the search from index 0.

Verification (HOLD_CYCLES=4)
REQ-028 REQ=0100 with DATA_2=0xBEEF for one cycle at edge k -> ACK=0100 for one cycle after k; DISP_VALID=1, DISP_SRC=2, DISP_DATA=0xBEEF after edge k+1; display stays on source 2 indefinitely through 5-cycle periods.
REQ-029 Load sources 0, 1 and 3 with 0x1111, 0x2222 and 0x3333 in the same cycle -> display sequence 0, 1, 3, 0, ..., each shown 5 cycles, source 2 skipped.
REQ-030 While source 1 is displayed, REQ[1]=1 with DATA_1=0xA5A5 -> DISP_DATA=0xA5A5 right after that edge; counter not restarted.
REQ-031 FREEZE=1 in SHOW for 10 cycles -> DISP_SRC unchanged for 10 extra cycles; the counter resumes from its held value when FREEZE falls.
REQ-032 CLR=1 and REQ=1111 in the same cycle -> no capture, ACK=0000, IDLE, DISP_VALID=0 and DISP_DATA=0 next cycle.
REQ-033 RST pulsed mid-SHOW while BUF is non-zero -> all outputs 0 asynchronously; after release with REQ=1000, the display shows source 3.
